// File: rtl/chord_pkg.sv
// Shared types, chord offset tables and tone helpers
// for the chord sequencer.
package chord_pkg;

    typedef enum logic [1:0] {
        CH_I  = 2'd0,
        CH_IV = 2'd1,
        CH_V  = 2'd2,
        CH_VI = 2'd3
    } chord_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_NOTE = 2'd1,
        PH_SIL  = 2'd2
    } phase_e;

    localparam logic [4:0] FREQ_NONE = 5'd31;

    // Row = chord (I, IV, V, vi), column = voice.
    localparam logic [0:15][4:0] MAJOR_OFS = {
        5'd0, 5'd4,  5'd7,  5'd12,
        5'd5, 5'd9,  5'd12, 5'd17,
        5'd7, 5'd11, 5'd14, 5'd19,
        5'd9, 5'd12, 5'd16, 5'd21
    };

    localparam logic [0:15][4:0] MINOR_OFS = {
        5'd0, 5'd3,  5'd7,  5'd12,
        5'd5, 5'd8,  5'd12, 5'd17,
        5'd7, 5'd11, 5'd14, 5'd19,
        5'd8, 5'd12, 5'd15, 5'd20
    };

    // Drop an octave when the tone would reach the "none" id.
    function automatic logic [4:0] fold(input logic [5:0] s);
        logic [5:0] t;
        t = (s > 6'd30) ? s - 6'd12 : s;
        return t[4:0];
    endfunction

    function automatic logic [4:0] chord_tone(
        input logic [4:0] base,
        input logic       minor,
        input chord_e     ch,
        input logic [1:0] k
    );
        logic [3:0] idx;
        logic [4:0] ofs;
        idx = {ch, k};
        ofs = minor ? MINOR_OFS[idx] : MAJOR_OFS[idx];
        return fold({1'b0, base} + {1'b0, ofs});
    endfunction

endpackage

// File: rtl/chord_player_pwm_dac.sv
// PWM DAC: free-running period counter, level latch,
// and the tick that paces the phase counters.
module pwm_dac #(
    parameter int BITS = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [BITS-1:0] level,
    output logic            tick,
    output logic            pwm
);

    logic [BITS-1:0] count;
    logic [BITS-1:0] lvl_latched;

    assign tick = (count == '0);

    // Period counter wraps every 2^BITS clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count <= '0;
        else        count <= count + BITS'(1);
    end

    // Level is sampled only at period start so duty never changes mid-period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lvl_latched <= '0;
            pwm         <= 1'b0;
        end else if (tick) begin
            lvl_latched <= level;
            pwm         <= (level != '0);
        end else if (count == lvl_latched) begin
            pwm <= 1'b0;
        end
    end

endmodule

// File: rtl/chord_player.sv
// Chord sequencer and PWM mixer: derives key from game ids,
// steps I-IV-V-vi with note/silence phases, drives voices.
module chord_player
    import chord_pkg::*;
#(
    parameter int VOICES      = 4,
    parameter int BITS        = 6,
    parameter int NOTE_LENGTH = 20,
    parameter int SIL_LENGTH  = 17
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             freq_id1,
    input  logic [4:0]             freq_id2,
    input  logic                   new_f,
    input  logic                   music,
    input  logic [VOICES*BITS-1:0] levels,
    output logic [VOICES*5-1:0]    voice_freq,
    output logic                   voice_new_f,
    output logic [1:0]             chord_state,
    output logic                   sil,
    output logic                   note,
    output logic                   pwm
);

    localparam int CW = (NOTE_LENGTH > SIL_LENGTH) ? NOTE_LENGTH : SIL_LENGTH;
    localparam int SH = (VOICES == 4) ? 2 : (VOICES == 2) ? 1 : 0;
    localparam int SW = BITS + 2;
    localparam logic [CW-1:0] NOTE_LAST = CW'((64'd1 << NOTE_LENGTH) - 64'd1);
    localparam logic [CW-1:0] SIL_LAST  = CW'((64'd1 << SIL_LENGTH) - 64'd1);

    phase_e          state_q, state_d;
    logic [CW-1:0]   ph_cnt_q, ph_cnt_d;
    chord_e          chord_q, chord_d;
    logic [4:0]      base_q;
    logic            minor_q;
    logic            music_q;
    logic            tick;
    logic            reload;
    logic            load_en;
    logic            music_rise;
    logic            sil_next;

    logic [4:0]      lower, diff, new_base;
    logic            new_minor;
    logic [4:0]      ld_base;
    logic            ld_minor;

    logic [VOICES*5-1:0] tone_vec, direct_vec, load_vec;
    logic [SW-1:0]       sum, pair_mix;
    logic [BITS-1:0]     mix_d, mix_q, dac_level;

    assign music_rise  = music & ~music_q;
    assign note        = music && (state_q == PH_NOTE);
    assign sil         = music && (state_q == PH_SIL);
    assign sil_next    = music && (state_d == PH_SIL);
    assign chord_state = chord_q;

    // Key detection from the raw game ids.
    always_comb begin
        lower     = (freq_id2 < freq_id1) ? freq_id2 : freq_id1;
        new_base  = (lower < 5'd13) ? lower : lower - 5'd12;
        diff      = (freq_id1 > freq_id2) ? freq_id1 - freq_id2
                                          : freq_id2 - freq_id1;
        new_minor = (freq_id2 != FREQ_NONE) && (diff == 5'd3);
    end

    // Phase FSM next state; new_f overrides any phase boundary.
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        chord_d  = chord_q;
        reload   = 1'b0;
        if (new_f) begin
            state_d  = PH_NOTE;
            ph_cnt_d = '0;
            chord_d  = CH_I;
            reload   = 1'b1;
        end else if (!music) begin
            ph_cnt_d = '0;
            if (state_q != PH_IDLE) state_d = PH_NOTE;
        end else if (music_rise) begin
            state_d  = PH_NOTE;
            ph_cnt_d = '0;
            reload   = 1'b1;
        end else if (tick) begin
            unique case (state_q)
                PH_NOTE: begin
                    if (ph_cnt_q == NOTE_LAST) begin
                        state_d  = PH_SIL;
                        ph_cnt_d = '0;
                    end else begin
                        ph_cnt_d = ph_cnt_q + CW'(1);
                    end
                end
                PH_SIL: begin
                    if (ph_cnt_q == SIL_LAST) begin
                        state_d  = PH_NOTE;
                        ph_cnt_d = '0;
                        chord_d  = chord_e'(chord_q + 2'd1);
                        reload   = 1'b1;
                    end else begin
                        ph_cnt_d = ph_cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Phase, progression and key registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= PH_IDLE;
            ph_cnt_q <= '0;
            chord_q  <= CH_I;
            base_q   <= '0;
            minor_q  <= 1'b0;
            music_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ph_cnt_q <= ph_cnt_d;
            chord_q  <= chord_d;
            music_q  <= music;
            if (new_f) begin
                base_q  <= new_base;
                minor_q <= new_minor;
            end
        end
    end

    // Chord tones for the chord about to be played.
    always_comb begin
        ld_base  = new_f ? new_base : base_q;
        ld_minor = new_f ? new_minor : minor_q;
        tone_vec = '0;
        for (int k = 0; k < VOICES; k++)
            tone_vec[k*5 +: 5] = chord_tone(ld_base, ld_minor, chord_d, 2'(k));
    end

    generate
        if (VOICES == 1) begin : g_one
            // Single voice plays id1 only.
            always_comb begin
                direct_vec = freq_id1;
                pair_mix   = SW'(levels[BITS-1:0]);
            end
        end else begin : g_multi
            // Two-tone fallback on voices 0 and 1.
            always_comb begin
                direct_vec      = {VOICES{FREQ_NONE}};
                direct_vec[4:0] = freq_id1;
                direct_vec[9:5] = freq_id2;
                pair_mix = (SW'(levels[BITS-1:0])
                         + SW'(levels[2*BITS-1:BITS])) >> 1;
            end
        end
    endgenerate

    // Direct mode only rewrites voices when the ids actually differ.
    always_comb begin
        load_vec = music ? tone_vec : direct_vec;
        load_en  = reload || (!music && (direct_vec != voice_freq));
    end

    // Voice registers and their change pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            voice_freq  <= {VOICES{FREQ_NONE}};
            voice_new_f <= 1'b0;
        end else begin
            voice_new_f <= load_en;
            if (load_en) voice_freq <= load_vec;
        end
    end

    // Average of all voice levels; muted in silence.
    always_comb begin
        sum = '0;
        for (int k = 0; k < VOICES; k++)
            sum = sum + SW'(levels[k*BITS +: BITS]);
        if (music) mix_d = sil ? '0 : BITS'(sum >> SH);
        else       mix_d = BITS'(pair_mix);
    end

    // Registered mix level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mix_q <= '0;
        else        mix_q <= mix_d;
    end

    // A period starting on the silence boundary must already be muted.
    assign dac_level = sil_next ? '0 : mix_q;

    pwm_dac #(.BITS(BITS)) u_dac (
        .clock (clock),
        .reset (reset),
        .level (dac_level),
        .tick  (tick),
        .pwm   (pwm)
    );

endmodule

// File: tb/tb_chord_player.sv
// Scoreboard bench for chord_player: expected voice sets are
// queued at stimulus time and checked on each voice_new_f.
module tb_chord_player;

    localparam int VOICES = 4;
    localparam int BITS   = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  freq_id1 = 5'd0;
    logic [4:0]  freq_id2 = 5'd31;
    logic        new_f = 1'b0;
    logic        music = 1'b1;
    logic [23:0] levels = '0;
    logic [19:0] voice_freq;
    logic        voice_new_f;
    logic [1:0]  chord_state;
    logic        sil;
    logic        note;
    logic        pwm;

    typedef struct packed {
        logic [19:0] v;
        logic [1:0]  ch;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    chord_player #(
        .VOICES(VOICES), .BITS(BITS), .NOTE_LENGTH(2), .SIL_LENGTH(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .freq_id1    (freq_id1),
        .freq_id2    (freq_id2),
        .new_f       (new_f),
        .music       (music),
        .levels      (levels),
        .voice_freq  (voice_freq),
        .voice_new_f (voice_new_f),
        .chord_state (chord_state),
        .sil         (sil),
        .note        (note),
        .pwm         (pwm)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input int b, input int c,
                        input int d, input int ch);
        exp_t e;
        e.v  = {5'(d), 5'(c), 5'(b), 5'(a)};
        e.ch = 2'(ch);
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d entries left, expected 0",
                     name, sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_new_f(input logic [4:0] a, input logic [4:0] b);
        @(posedge clock); #1;
        freq_id1 = a;
        freq_id2 = b;
        new_f    = 1'b1;
        @(posedge clock); #1;
        new_f = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_voice_freq"}, voice_freq, 20'hFFFFF);
        chk({tag, "_voice_new_f"}, voice_new_f, 0);
        chk({tag, "_chord"}, chord_state, 0);
        chk({tag, "_sil"}, sil, 0);
        chk({tag, "_note"}, note, 0);
        chk({tag, "_pwm"}, pwm, 0);
    endtask

    // Monitor: every voice_new_f must match the next queued expectation.
    always @(negedge clock) begin : mon
        exp_t e;
        if (voice_new_f === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_voice_new_f: got voices %h, expected no pulse",
                         voice_freq);
            end else begin
                e = sb.pop_front();
                chk("voice_freq", voice_freq, e.v);
                chk("chord_state", chord_state, e.ch);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int len;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset");
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (4) @(posedge clock);

        // Base 5 major, full progression back to I.
        push(5, 9, 12, 17, 0);
        pulse_new_f(5'd5, 5'd31);
        @(negedge clock);
        chk("note_after_new_f", note, 1);
        chk("sil_after_new_f", sil, 0);
        chk("chord_after_new_f", chord_state, 0);
        push(10, 14, 17, 22, 1);
        push(12, 16, 19, 24, 2);
        push(14, 17, 21, 26, 3);
        push(5, 9, 12, 17, 0);
        drain("major5_prog", 2500);

        // Base 8 minor.
        push(8, 11, 15, 20, 0);
        pulse_new_f(5'd20, 5'd23);
        push(13, 16, 20, 25, 1);
        push(15, 19, 22, 27, 2);
        push(16, 20, 23, 28, 3);
        drain("minor8_prog", 2000);

        // Base 12 major: V and vi fold.
        push(12, 16, 19, 24, 0);
        pulse_new_f(5'd12, 5'd31);
        push(17, 21, 24, 29, 1);
        push(19, 23, 26, 19, 2);
        push(21, 24, 28, 21, 3);
        drain("major12_prog", 2000);

        // Direct two-tone mode.
        push(7, 31, 31, 31, 0);
        @(posedge clock); #1;
        music    = 1'b0;
        freq_id1 = 5'd7;
        freq_id2 = 5'd31;
        levels   = {6'd0, 6'd0, 6'd20, 6'd40};
        new_f    = 1'b1;
        @(posedge clock); #1;
        new_f = 1'b0;
        drain("direct_load", 10);
        @(negedge clock);
        chk("direct_note", note, 0);
        chk("direct_sil", sil, 0);
        repeat (192) @(negedge clock);
        n = 0;
        repeat (64) begin
            @(negedge clock);
            if (pwm) n++;
        end
        chk("direct_pwm_high", n, 30);

        // Back to music with full levels; silence must be quiet.
        push(7, 11, 14, 19, 0);
        push(12, 16, 19, 24, 1);
        @(posedge clock); #1;
        music  = 1'b1;
        levels = {4{6'd63}};
        n = 0;
        while (sil !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("sil_reached", sil, 1);
        n   = 0;
        len = 0;
        while (sil === 1'b1 && len < 500) begin
            if (pwm) n++;
            len++;
            @(negedge clock);
        end
        chk("sil_pwm_high", n, 0);
        chk("sil_length", len, 128);
        drain("reload_iv", 20);
        repeat (5) @(negedge clock);
        chk("note_before_reset", note, 1);

        // Asynchronous reset mid-note.
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        #4;
        reset = 1'b1;
        repeat (3) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
